// File: rtl/rv_core_pkg.sv
// Shared core constants: datapath width, register address width and the x0 index.
package rv_core_pkg;
  localparam int XLEN     = 32;
  localparam int AW       = 5;
  localparam int REG_ZERO = 0;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for RAW-hazard detection: flush > set > clear, plus a lookup per read port.
module regfile_scoreboard #(
  parameter int AW   = rv_core_pkg::AW,
  parameter int NREG = 2**AW,
  parameter int NRD  = 2
)(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              sb_set,
  input  logic [AW-1:0]     sb_addr,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic              flush,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    busy_o
);
  import rv_core_pkg::*;

  logic [NREG-1:0]    busy;
  logic [2**AW-1:0]   busyExt;

  // A retiring write and a new producer on the same register leave it busy.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) busy <= '0;
    else begin
      for (int r = 0; r < NREG; r++) begin
        if (r == REG_ZERO || flush)           busy[r] <= 1'b0;
        else if (sb_set && 32'(sb_addr) == r) busy[r] <= 1'b1;
        else if (we && 32'(wa) == r)          busy[r] <= 1'b0;
      end
    end
  end

  // Zero-extend so addresses at or above NREG look up as not busy.
  always_comb begin
    busyExt = '0;
    busyExt[NREG-1:0] = busy;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_lk
    assign busy_o[i] = busyExt[rd_addr[i*AW +: AW]];
  end
endmodule

// File: rtl/regfile_bypass_sb.sv
// Integer register file: NRD combinational read ports with optional write-first bypass,
// one write port, busy scoreboard and a fixed debug tap.
module regfile_bypass_sb #(
  parameter int XLEN    = rv_core_pkg::XLEN,
  parameter int AW      = rv_core_pkg::AW,
  parameter int NREG    = 2**AW,
  parameter int NRD     = 2,
  parameter int BYPASS  = 1,
  parameter int DBG_IDX = 3
)(
  input  logic                CLK,
  input  logic                RESET,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_addr,
  input  logic                flush,
  output logic [XLEN-1:0]     dbg_data
);
  import rv_core_pkg::*;

  logic [XLEN-1:0] regs [NREG];
  logic [NRD-1:0]  sbBusy;
  logic            weOk;

  assign weOk = we && 32'(wa) != REG_ZERO && 32'(wa) < NREG;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else if (weOk) begin
      for (int r = 1; r < NREG; r++)
        if (32'(wa) == r) regs[r] <= wd;
    end
  end

  regfile_scoreboard #(.AW(AW), .NREG(NREG), .NRD(NRD)) u_sb (
    .CLK    (CLK),
    .RESET  (RESET),
    .sb_set (sb_set),
    .sb_addr(sb_addr),
    .we     (we),
    .wa     (wa),
    .flush  (flush),
    .rd_addr(rd_addr),
    .busy_o (sbBusy)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] stored;
    logic            valid, hit;

    assign a     = rd_addr[i*AW +: AW];
    assign valid = 32'(a) != REG_ZERO && 32'(a) < NREG;
    assign hit   = BYPASS != 0 && we && wa == a && valid;

    always_comb begin
      stored = '0;
      for (int r = 1; r < NREG; r++)
        if (32'(a) == r) stored = regs[r];
    end

    // Outputs are forced quiet during reset so a bypassed write cannot leak through.
    assign rd_data[i*XLEN +: XLEN] = (RESET || !valid) ? '0 : (hit ? wd : stored);
    assign rd_busy[i] = !RESET && valid && sbBusy[i] && !hit;
  end

  if (DBG_IDX > 0 && DBG_IDX < NREG) begin : g_dbg
    assign dbg_data = RESET ? '0 : regs[DBG_IDX];
  end else begin : g_nodbg
    assign dbg_data = '0;
  end
endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Directed bench: a write-first instance (NREG=16, so addresses 16..31 are out of range)
// and a no-bypass instance (NREG=32) share every input.
module tb_regfile_bypass_sb;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NRD  = 3;

  logic                CLK = 1'b0;
  logic                RESET;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] bData, nData;
  logic [NRD-1:0]      bBusy, nBusy;
  logic                we, sb_set, flush;
  logic [AW-1:0]       wa, sb_addr;
  logic [XLEN-1:0]     wd, bDbg, nDbg;

  int pass = 0;
  int total = 0;

  always #5 CLK = ~CLK;

  regfile_bypass_sb #(.XLEN(XLEN), .AW(AW), .NREG(16), .NRD(NRD), .BYPASS(1), .DBG_IDX(3)) u_byp (
    .CLK(CLK), .RESET(RESET), .rd_addr(rd_addr), .rd_data(bData), .rd_busy(bBusy),
    .we(we), .wa(wa), .wd(wd), .sb_set(sb_set), .sb_addr(sb_addr), .flush(flush), .dbg_data(bDbg));

  regfile_bypass_sb #(.XLEN(XLEN), .AW(AW), .NREG(32), .NRD(NRD), .BYPASS(0), .DBG_IDX(3)) u_nbp (
    .CLK(CLK), .RESET(RESET), .rd_addr(rd_addr), .rd_data(nData), .rd_busy(nBusy),
    .we(we), .wa(wa), .wd(wd), .sb_set(sb_set), .sb_addr(sb_addr), .flush(flush), .dbg_data(nDbg));

  task automatic idle();
    we = 0; wa = '0; wd = '0; sb_set = 0; sb_addr = '0; flush = 0;
  endtask

  task automatic rd3(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    rd_addr = {a2, a1, a0};
  endtask

  // Advance through the next rising edge; sample 1 ns later.
  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    RESET = 1; idle();
    we = 1; wa = 5; wd = 32'hDEADBEEF; rd3(5, 5, 0);
    #3;
    total++; if (bData[31:0] !== 32'h0) $display("FAIL rst_bypass_gate got %h want 0", bData[31:0]); else pass++;
    total++; if (bBusy !== 3'b000 || nBusy !== 3'b000) $display("FAIL rst_busy got %b/%b want 000", bBusy, nBusy); else pass++;
    total++; if (bDbg !== 32'h0) $display("FAIL rst_dbg got %h want 0", bDbg); else pass++;
    #5 RESET = 0;
    sb_set = 1; sb_addr = 5;
    tick();
    idle();
    #1;
    total++; if (bData[31:0] !== 32'hDEADBEEF) $display("FAIL wr_x5 got %h want deadbeef", bData[31:0]); else pass++;
    total++; if (bBusy[0] !== 1'b1) $display("FAIL set_x5_busy got %b want 1", bBusy[0]); else pass++;
    RESET = 1;
    #1;
    total++; if (bData[31:0] !== 32'h0 || nData[31:0] !== 32'h0) $display("FAIL async_rst_data got %h/%h want 0", bData[31:0], nData[31:0]); else pass++;
    #1;
    RESET = 0;
    #1;
    total++; if (bData[31:0] !== 32'h0 || bBusy[0] !== 1'b0) $display("FAIL post_rst_state got %h/%b want 0/0", bData[31:0], bBusy[0]); else pass++;
  endtask

  task automatic test_x0();
    idle(); we = 1; wa = 0; wd = 32'hFFFFFFFF; rd3(0, 0, 0);
    #1;
    total++; if (bData !== '0 || nData !== '0) $display("FAIL x0_same got %h/%h want 0", bData, nData); else pass++;
    tick(); idle(); #1;
    total++; if (bData !== '0 || nData !== '0) $display("FAIL x0_next got %h/%h want 0", bData, nData); else pass++;
  endtask

  task automatic test_bypass();
    idle(); we = 1; wa = 7; wd = 32'h11111111; sb_set = 1; sb_addr = 7; rd3(7, 7, 0);
    tick();
    idle(); we = 1; wa = 7; wd = 32'h12345678;
    #1;
    total++; if (bData[31:0] !== 32'h12345678) $display("FAIL byp_data got %h want 12345678", bData[31:0]); else pass++;
    total++; if (bBusy[0] !== 1'b0) $display("FAIL byp_busy_mask got %b want 0", bBusy[0]); else pass++;
    total++; if (nData[31:0] !== 32'h11111111) $display("FAIL nbp_old got %h want 11111111", nData[31:0]); else pass++;
    total++; if (nBusy[0] !== 1'b1) $display("FAIL nbp_busy got %b want 1", nBusy[0]); else pass++;
    tick(); idle(); #1;
    total++; if (nData[31:0] !== 32'h12345678 || nBusy[0] !== 1'b0) $display("FAIL nbp_next got %h/%b want 12345678/0", nData[31:0], nBusy[0]); else pass++;
  endtask

  task automatic test_scoreboard();
    idle(); rd3(10, 12, 10); sb_set = 1; sb_addr = 10;
    #1;
    total++; if (bBusy[0] !== 1'b0) $display("FAIL sb_before got %b want 0", bBusy[0]); else pass++;
    tick(); idle(); #1;
    total++; if (bBusy !== 3'b101 || nBusy !== 3'b101) $display("FAIL sb_set got %b/%b want 101", bBusy, nBusy); else pass++;
    we = 1; wa = 10; wd = 32'h55; sb_set = 1; sb_addr = 10;
    tick(); idle(); #1;
    total++; if (bBusy[0] !== 1'b1 || nBusy[0] !== 1'b1) $display("FAIL sb_set_wins got %b/%b want 1", bBusy[0], nBusy[0]); else pass++;
    we = 1; wa = 10; wd = 32'h66; sb_set = 1; sb_addr = 12;
    tick(); idle(); #1;
    total++; if (bBusy !== 3'b010 || nBusy !== 3'b010) $display("FAIL sb_clr_other got %b/%b want 010", bBusy, nBusy); else pass++;
  endtask

  task automatic test_flush();
    idle(); sb_set = 1; sb_addr = 3; tick();
    sb_addr = 4; tick();
    sb_addr = 9; tick();
    idle(); rd3(3, 4, 9); #1;
    total++; if (bBusy !== 3'b111) $display("FAIL fl_pre got %b want 111", bBusy); else pass++;
    flush = 1; sb_set = 1; sb_addr = 11;
    tick(); idle(); #1;
    total++; if (bBusy !== 3'b000 || nBusy !== 3'b000) $display("FAIL fl_clear got %b/%b want 000", bBusy, nBusy); else pass++;
    rd3(11, 12, 0); #1;
    total++; if (bBusy !== 3'b000 || nBusy !== 3'b000) $display("FAIL fl_over_set got %b/%b want 000", bBusy, nBusy); else pass++;
  endtask

  task automatic test_multiport();
    idle(); we = 1; wa = 3; wd = 32'hA5; tick(); idle();
    rd3(3, 3, 3); #1;
    total++; if (bData !== {3{32'hA5}} || nData !== {3{32'hA5}}) $display("FAIL mp_data got %h/%h want a5 x3", bData, nData); else pass++;
    total++; if (bDbg !== 32'hA5 || nDbg !== 32'hA5) $display("FAIL dbg got %h/%h want a5", bDbg, nDbg); else pass++;
    we = 1; wa = 3; wd = 32'h77; #1;
    total++; if (bDbg !== 32'hA5) $display("FAIL dbg_no_byp got %h want a5", bDbg); else pass++;
    tick(); idle();
  endtask

  task automatic test_range();
    idle(); we = 1; wa = 20; wd = 32'hCAFE; sb_set = 1; sb_addr = 20; rd3(20, 15, 0);
    #1;
    total++; if (bData[31:0] !== 32'h0 || bBusy[0] !== 1'b0) $display("FAIL oor_same got %h/%b want 0/0", bData[31:0], bBusy[0]); else pass++;
    tick(); idle(); #1;
    total++; if (bData[31:0] !== 32'h0 || bBusy[0] !== 1'b0) $display("FAIL oor_next got %h/%b want 0/0", bData[31:0], bBusy[0]); else pass++;
    total++; if (nData[31:0] !== 32'hCAFE || nBusy[0] !== 1'b1) $display("FAIL x20_wide got %h/%b want cafe/1", nData[31:0], nBusy[0]); else pass++;
  endtask

  initial begin
    rd_addr = '0;
    test_reset();
    test_x0();
    test_bypass();
    test_scoreboard();
    test_flush();
    test_multiport();
    test_range();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
